// File: rtl/fsrcnn_pkg.sv
// -----------------------------------------------------------------------------
// fsrcnn_pkg
// Shared definitions for the FSRCNN control path: the stage sequencer state
// encoding, the number of datapath stages and the index of each stage.
// No ports (package).
// -----------------------------------------------------------------------------
package fsrcnn_pkg;

  // Number of datapath stages sequenced for one frame.
  localparam int NUM_STAGES = 9;

  // Stage indices, in execution order.
  localparam int STG_FE     = 0;
  localparam int STG_PRELU1 = 1;
  localparam int STG_SHRINK = 2;
  localparam int STG_PRELU2 = 3;
  localparam int STG_MAP    = 4;
  localparam int STG_PRELU3 = 5;
  localparam int STG_EXPAND = 6;
  localparam int STG_PRELU4 = 7;
  localparam int STG_DECONV = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/stage_watchdog.sv
// -----------------------------------------------------------------------------
// stage_watchdog
// Counts cycles a stage spends waiting for its done. 'expired' is asserted in
// the TIMEOUT_CYCLES-th enabled cycle after a clear, so the owner can leave
// on that same edge. TIMEOUT_CYCLES = 0 disables the watchdog.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clear   in   restart the count (stage just launched)
//   enable  in   count this cycle (stage is waiting)
//   expired out  waiting limit reached this cycle
// -----------------------------------------------------------------------------
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (count_reg == LAST_CNT);
    end
  endgenerate

endmodule

// File: rtl/fsrcnn_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fsrcnn_stage_sequencer
// Runs the FSRCNN stages of one frame in order: for each stage it pulses that
// stage's start for one cycle, then waits for its done before launching the
// next. After the last stage it pulses frame_done_out and counts the frame.
// A watchdog supervises every wait; on expiry the sequencer parks in ERROR
// until clear_err_in. abort_in drops the current frame.
//
// Ports:
//   clk_in           in   clock, rising edge
//   rst_in           in   asynchronous active-low reset
//   frame_valid_in   in   frame request
//   frame_ready_out  out  request accepted this cycle if valid (IDLE, no abort)
//   stage_start_out  out  one-hot start pulse to the current stage
//   stage_done_in    in   per-stage done (level or pulse)
//   abort_in         in   abandon current frame (LAUNCH/WAIT/DONE only)
//   clear_err_in     in   leave ERROR
//   frame_done_out   out  one-cycle pulse after the last stage completes
//   busy_out         out  frame in progress
//   stage_idx_out    out  index of current stage
//   error_out        out  watchdog fired, held until cleared
//   error_stage_out  out  stage that timed out (kept after clear)
//   frame_count_out  out  completed frames, wraps
// -----------------------------------------------------------------------------
module fsrcnn_stage_sequencer #(
  parameter int NUM_STAGES     = fsrcnn_pkg::NUM_STAGES,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FCNT_W         = 16,
  localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_valid_in,
  output logic                  frame_ready_out,
  output logic [NUM_STAGES-1:0] stage_start_out,
  input  logic [NUM_STAGES-1:0] stage_done_in,
  input  logic                  abort_in,
  input  logic                  clear_err_in,
  output logic                  frame_done_out,
  output logic                  busy_out,
  output logic [IDX_W-1:0]      stage_idx_out,
  output logic                  error_out,
  output logic [IDX_W-1:0]      error_stage_out,
  output logic [FCNT_W-1:0]     frame_count_out
);

  import fsrcnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t            state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [IDX_W-1:0]      err_stage_reg, err_stage_next;
  logic [FCNT_W-1:0]     fcount_reg, fcount_next;
  logic [NUM_STAGES-1:0] idx_onehot;
  logic                  done_sel;
  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expired;
  logic                  abortable;

  // One-hot decode of the current stage; used both for the start pulse and
  // to pick the only done bit that matters (other stages' done are ignored).
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign done_sel = |(stage_done_in & idx_onehot);

  assign wd_clear  = (state_reg == ST_LAUNCH);
  assign wd_enable = (state_reg == ST_WAIT);

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign abortable = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT) ||
                     (state_reg == ST_DONE);

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    err_stage_next = err_stage_reg;
    fcount_next    = fcount_reg;

    case (state_reg)
      ST_IDLE: begin
        if (frame_valid_in && frame_ready_out) begin
          idx_next   = '0;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Done is deliberately not looked at here.
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (done_sel) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = ST_LAUNCH;
          end
        end else if (wd_expired) begin
          err_stage_next = idx_reg;
          state_next     = ST_ERROR;
        end
      end
      ST_DONE: begin
        fcount_next = fcount_reg + FCNT_W'(1);
        state_next  = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_err_in) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything above, including the frame count update.
    if (abort_in && abortable) begin
      state_next     = ST_IDLE;
      idx_next       = '0;
      err_stage_next = err_stage_reg;
      fcount_next    = fcount_reg;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      err_stage_reg <= '0;
      fcount_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      err_stage_reg <= err_stage_next;
      fcount_reg    <= fcount_next;
    end
  end

  assign frame_ready_out = (state_reg == ST_IDLE) && !abort_in;
  assign stage_start_out = (state_reg == ST_LAUNCH) ? idx_onehot : '0;
  assign frame_done_out  = (state_reg == ST_DONE);
  assign busy_out        = (state_reg != ST_IDLE) && (state_reg != ST_ERROR);
  assign stage_idx_out   = idx_reg;
  assign error_out       = (state_reg == ST_ERROR);
  assign error_stage_out = err_stage_reg;
  assign frame_count_out = fcount_reg;

endmodule

// File: tb/tb_fsrcnn_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fsrcnn_stage_sequencer
// Directed bench. dut_a (timeout 20, 2-bit frame counter) carries the frame
// sequencing scenarios; dut_b (timeout 8) shares the same inputs and is used
// for the watchdog scenarios. A small responder answers each start pulse of
// dut_a with a done after a per-stage delay.
// -----------------------------------------------------------------------------
module tb_fsrcnn_stage_sequencer;

  localparam int NS = 9;

  logic          clk;
  logic          rst_n;
  logic          frame_valid;
  logic          abort;
  logic          clear_err;
  logic [NS-1:0] stage_done;

  logic          a_ready, a_done, a_busy, a_error;
  logic [NS-1:0] a_start;
  logic [3:0]    a_idx, a_estage;
  logic [1:0]    a_count;

  logic          b_ready, b_done, b_busy, b_error;
  logic [NS-1:0] b_start;
  logic [3:0]    b_idx, b_estage;
  logic [15:0]   b_count;

  fsrcnn_stage_sequencer #(
    .NUM_STAGES(NS), .TIMEOUT_CYCLES(20), .FCNT_W(2)
  ) dut_a (
    .clk_in(clk), .rst_in(rst_n), .frame_valid_in(frame_valid),
    .frame_ready_out(a_ready), .stage_start_out(a_start),
    .stage_done_in(stage_done), .abort_in(abort), .clear_err_in(clear_err),
    .frame_done_out(a_done), .busy_out(a_busy), .stage_idx_out(a_idx),
    .error_out(a_error), .error_stage_out(a_estage), .frame_count_out(a_count)
  );

  fsrcnn_stage_sequencer #(
    .NUM_STAGES(NS), .TIMEOUT_CYCLES(8), .FCNT_W(16)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_n), .frame_valid_in(frame_valid),
    .frame_ready_out(b_ready), .stage_start_out(b_start),
    .stage_done_in(stage_done), .abort_in(abort), .clear_err_in(clear_err),
    .frame_done_out(b_done), .busy_out(b_busy), .stage_idx_out(b_idx),
    .error_out(b_error), .error_stage_out(b_estage), .frame_count_out(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder and event log state.
  int            cyc = 0;
  int            base = 0;
  int            delay [NS];
  bit            stray_en = 0;
  bit            abort_on_last = 0;
  bit            pend = 0;
  int            pend_cnt = 0;
  int            pend_idx = 0;
  bit            done_prev = 0;
  int            start_cyc [$];
  logic [NS-1:0] start_vec [$];
  int            done_cyc [$];
  int            count_after [$];

  task automatic clear_logs();
    start_cyc.delete();
    start_vec.delete();
    done_cyc.delete();
    count_after.delete();
    done_prev = 0;
  endtask

  task automatic zero_delays();
    for (int k = 0; k < NS; k++) delay[k] = 0;
    stray_en      = 0;
    abort_on_last = 0;
  endtask

  // One clock: drive done/abort 1 time unit after the edge, sample 1 later.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    stage_done = '0;
    abort      = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        stage_done[pend_idx] = 1'b1;
        if (abort_on_last && pend_idx == NS - 1) abort = 1'b1;
        pend = 0;
      end else begin
        pend_cnt--;
        if (stray_en && pend_idx == 4) stage_done[6] = 1'b1;
      end
    end
    for (int k = 0; k < NS; k++) begin
      if (a_start[k]) begin
        pend     = 1;
        pend_idx = k;
        pend_cnt = delay[k];
      end
    end
    #1;
    if (a_start != '0) begin
      start_cyc.push_back(cyc - base);
      start_vec.push_back(a_start);
    end
    if (done_prev) count_after.push_back(int'(a_count));
    if (a_done) done_cyc.push_back(cyc - base);
    done_prev = a_done;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    abort       = 1'b0;
    clear_err   = 1'b0;
    stage_done  = '0;
    pend        = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle();
  endtask

  // Request one frame and run until it completes or the budget runs out.
  task automatic run_frame(input int budget);
    int dc;
    clear_logs();
    base        = cyc;
    frame_valid = 1'b1;
    cycle();
    frame_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() > 0 && count_after.size() > 0) break;
      cycle();
    end
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    $display("frame: starts=%0d done_cycle=%0d count=%0d",
             start_cyc.size(), dc, a_count);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, required finish before 200000");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int err_first;
    int s0 [$];
    logic [NS-1:0] exp_v;

    rst_n       = 1'b0;
    frame_valid = 1'b0;
    abort       = 1'b0;
    clear_err   = 1'b0;
    stage_done  = '0;
    zero_delays();

    // Reset values, observed while reset is held.
    #3;
    check_eq("rst_ready",  32'(a_ready),  1);
    check_eq("rst_start",  32'(a_start),  0);
    check_eq("rst_done",   32'(a_done),   0);
    check_eq("rst_busy",   32'(a_busy),   0);
    check_eq("rst_idx",    32'(a_idx),    0);
    check_eq("rst_error",  32'(a_error),  0);
    check_eq("rst_estage", 32'(a_estage), 0);
    check_eq("rst_count",  32'(a_count),  0);
    do_reset();

    // abort_in in IDLE only masks frame_ready_out.
    abort = 1'b1;
    #1;
    check_eq("idle_abort_ready", 32'(a_ready), 0);
    abort = 1'b0;
    #1;
    check_eq("idle_ready", 32'(a_ready), 1);

    // Single frame, every done in the first WAIT cycle.
    run_frame(60);
    check_eq("t1_nstarts", start_cyc.size(), NS);
    for (int k = 0; k < NS; k++) begin
      if (k < start_cyc.size()) begin
        exp_v = '0;
        exp_v[k] = 1'b1;
        check_eq($sformatf("t1_start%0d_cyc", k), start_cyc[k], 2 * k + 1);
        check_eq($sformatf("t1_start%0d_vec", k), 32'(start_vec[k]), 32'(exp_v));
      end
    end
    check_eq("t1_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_eq("t1_done_cyc", done_cyc[0], 19);
    check_eq("t1_count", 32'(a_count), 1);
    check_eq("t1_ready_c20", 32'(a_ready), 1);
    check_eq("t1_busy_c20", 32'(a_busy), 0);

    // Mapping stage done 10 cycles late; stray done on stage 6 meanwhile.
    zero_delays();
    delay[4] = 10;
    stray_en = 1;
    run_frame(80);
    check_eq("t2_nstarts", start_cyc.size(), NS);
    for (int k = 0; k < NS; k++) begin
      if (k < start_cyc.size()) begin
        exp_v = '0;
        exp_v[k] = 1'b1;
        check_eq($sformatf("t2_start%0d_cyc", k), start_cyc[k],
                 2 * k + 1 + ((k > 4) ? 10 : 0));
        check_eq($sformatf("t2_start%0d_vec", k), 32'(start_vec[k]), 32'(exp_v));
      end
    end
    if (done_cyc.size() > 0) check_eq("t2_done_cyc", done_cyc[0], 29);
    else check_eq("t2_done_seen", 0, 1);
    check_eq("t2_count", 32'(a_count), 2);

    // Abort in the same cycle as the deconvolution done.
    zero_delays();
    abort_on_last = 1;
    run_frame(25);
    check_eq("t3_ndone", done_cyc.size(), 0);
    check_eq("t3_count", 32'(a_count), 2);
    check_eq("t3_busy", 32'(a_busy), 0);
    check_eq("t3_ready", 32'(a_ready), 1);
    check_eq("t3_idx", 32'(a_idx), 0);
    check_eq("t3_nstarts", start_cyc.size(), NS);

    // Back-to-back frames with frame_valid held high; 2-bit counter wraps.
    zero_delays();
    do_reset();
    clear_logs();
    frame_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      if (count_after.size() >= 5) break;
      cycle();
    end
    frame_valid = 1'b0;
    $display("back-to-back: frames=%0d count=%0d", count_after.size(), a_count);
    check_eq("t4_nframes", count_after.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < count_after.size())
        check_eq($sformatf("t4_count%0d", i), count_after[i], (i + 1) % 4);
    end
    s0.delete();
    for (int i = 0; i < start_vec.size(); i++)
      if (start_vec[i] == 9'd1) s0.push_back(start_cyc[i]);
    check_eq("t4_naccept", s0.size(), 5);
    for (int i = 0; i + 1 < s0.size(); i++)
      check_eq($sformatf("t4_interval%0d", i), s0[i + 1] - s0[i], 20);

    // Asynchronous reset while stage 3 is waiting.
    zero_delays();
    delay[3] = 5;
    clear_logs();
    base        = cyc;
    frame_valid = 1'b1;
    cycle();
    frame_valid = 1'b0;
    while ((cyc - base) < 9) cycle();
    check_eq("t5_pre_busy", 32'(a_busy), 1);
    check_eq("t5_pre_idx", 32'(a_idx), 3);
    rst_n = 1'b0;
    #1;
    check_eq("t5_busy", 32'(a_busy), 0);
    check_eq("t5_idx", 32'(a_idx), 0);
    check_eq("t5_ready", 32'(a_ready), 1);
    check_eq("t5_count", 32'(a_count), 0);
    check_eq("t5_b_busy", 32'(b_busy), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    pend  = 0;
    zero_delays();
    run_frame(60);
    if (start_vec.size() > 0) begin
      check_eq("t5_first_vec", 32'(start_vec[0]), 1);
      check_eq("t5_first_cyc", start_cyc[0], 1);
    end else begin
      check_eq("t5_first_seen", 0, 1);
    end
    if (done_cyc.size() > 0) check_eq("t5_done_cyc", done_cyc[0], 19);
    check_eq("t5_count_after", 32'(a_count), 1);

    // dut_b: done arriving in the very cycle the watchdog expires.
    do_reset();
    zero_delays();
    delay[1] = 7;
    run_frame(60);
    if (done_cyc.size() > 0) check_eq("t6_done_cyc", done_cyc[0], 26);
    check_eq("t6_b_error", 32'(b_error), 0);
    check_eq("t6_b_count", 32'(b_count), 1);

    // dut_b: shrinking stage never completes.
    do_reset();
    zero_delays();
    delay[2] = 1000;
    clear_logs();
    err_first   = -1;
    base        = cyc;
    frame_valid = 1'b1;
    cycle();
    frame_valid = 1'b0;
    while ((cyc - base) < 20) begin
      cycle();
      if (b_error && err_first < 0) err_first = cyc - base;
      if ((cyc - base) == 13) begin
        check_eq("t7_c13_b_error", 32'(b_error), 0);
        check_eq("t7_c13_b_busy", 32'(b_busy), 1);
      end
    end
    $display("watchdog: error at cycle %0d, stage %0d", err_first, b_estage);
    check_eq("t7_err_cycle", err_first, 14);
    check_eq("t7_b_error", 32'(b_error), 1);
    check_eq("t7_b_estage", 32'(b_estage), 2);
    check_eq("t7_b_busy", 32'(b_busy), 0);
    check_eq("t7_b_ready", 32'(b_ready), 0);
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    check_eq("t7_clr_b_error", 32'(b_error), 0);
    check_eq("t7_clr_b_ready", 32'(b_ready), 1);
    check_eq("t7_clr_b_estage", 32'(b_estage), 2);
    check_eq("t7_a_still_busy", 32'(a_busy), 1);
    check_eq("t7_a_error", 32'(a_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
